// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB command arbiter.
package sccb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int SCCB_CMD_W         = 16;
  localparam int REGA_MSB           = 15;
  localparam int VALUE_MSB          = 7;
  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 2_000_000;

  function automatic logic [7:0] cmd_rega(input logic [SCCB_CMD_W-1:0] cmd);
    return cmd[REGA_MSB:VALUE_MSB+1];
  endfunction

  function automatic logic [7:0] cmd_value(input logic [SCCB_CMD_W-1:0] cmd);
    return cmd[VALUE_MSB:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot_s;
  logic [IW-1:0] off_s;
  logic [IW:0]   sum_s;

  // Rotate so bit 0 is the pointer position, find the lowest set bit, rotate back.
  always_comb begin
    rot_s = N'({valid, valid} >> ptr);
    found = |rot_s;
    off_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IW'(i) : off_s;
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    idx   = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : sum_s[IW-1:0];
  end

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Round-robin arbiter sharing one SCCB write engine among NUM_REQ command sources.
// Optional burst locking is enabled with macro SCCB_ARB_LOCK_EN.
module sccb_cmd_arbiter
  import sccb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [SCCB_CMD_W*NUM_REQ-1:0] req_cmd,
`ifdef SCCB_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_err,
  output logic                          send,
  output logic [7:0]                    rega,
  output logic [7:0]                    value,
  input  logic                          taken,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [7:0]          rega_q, rega_d;
  logic [7:0]          value_q, value_d;
  logic                send_q, send_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [GW-1:0]       gap_q, gap_d;

  logic                  pick_found_s;
  logic [IDW-1:0]        pick_idx_s;
  logic [SCCB_CMD_W-1:0] pick_cmd_s;
  logic [IDW-1:0]        rr_next_s;
  logic                  keep_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign pick_cmd_s = req_cmd[pick_idx_s*SCCB_CMD_W +: SCCB_CMD_W];
  assign rr_next_s  = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

`ifdef SCCB_ARB_LOCK_EN
  // A locked requester keeps the pointer on an ack; a timeout always moves it on.
  assign keep_s = req_lock[grant_q];
`else
  assign keep_s = 1'b0;
`endif

  // Next-state and output logic for the IDLE/ISSUE/GAP sequencer.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    rega_d  = rega_q;
    value_d = value_q;
    send_d  = send_q;
    ack_d   = '0;
    err_d   = '0;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          rega_d  = cmd_rega(pick_cmd_s);
          value_d = cmd_value(pick_cmd_s);
          send_d  = 1'b1;
          tmo_d   = '0;
          state_d = ISSUE;
        end else begin
          send_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (taken) begin
          send_d         = 1'b0;
          ack_d[grant_q] = 1'b1;
          rr_d           = keep_s ? grant_q : rr_next_s;
          gap_d          = '0;
          state_d        = GAP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          send_d         = 1'b0;
          err_d[grant_q] = 1'b1;
          rr_d           = rr_next_s;
          gap_d          = '0;
          state_d        = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops send without acknowledging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      rega_q  <= 8'h00;
      value_q <= 8'h00;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      rega_q  <= rega_d;
      value_q <= value_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  assign req_ack  = ack_q;
  assign req_err  = err_q;
  assign send     = send_q;
  assign rega     = rega_q;
  assign value    = value_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Scoreboard bench for sccb_cmd_arbiter: stimulus pushes expected ack/err events,
// a monitor pops and compares them whenever req_ack or req_err pulses.
module tb_sccb_cmd_arbiter;

  localparam int NR  = 2;
  localparam int GAP = 16;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_cmd;
  logic [1:0]  req_ack;
  logic [1:0]  req_err;
  logic        send;
  logic [7:0]  rega;
  logic [7:0]  value;
  logic        taken;
  logic        busy;
  logic [0:0]  grant_id;
`ifdef SCCB_ARB_LOCK_EN
  logic [1:0]  req_lock;
`endif

  always #5 clk = ~clk;

  sccb_cmd_arbiter #(
    .NUM_REQ        (NR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
`ifdef SCCB_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ack   (req_ack),
    .req_err   (req_err),
    .send      (send),
    .rega      (rega),
    .value     (value),
    .taken     (taken),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct packed {
    logic       is_err;
    logic [3:0] id;
    logic [7:0] rega;
    logic [7:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Engine model: pulses taken eng_delay cycles after send rises; spur injects stray pulses.
  int   eng_delay;
  logic eng_en;
  logic spur;
  int   eng_cnt;
  initial begin
    taken   = 1'b0;
    eng_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (send && eng_en) eng_cnt = eng_cnt + 1;
      else eng_cnt = 0;
      taken = (eng_en && send && eng_cnt == eng_delay) || spur;
    end
  end

  // Scoreboard monitor.
  exp_t       mon_e;
  logic [1:0] mon_ea, mon_ee;
  initial begin
    forever begin
      @(negedge clk);
      if (req_ack != 2'b00 || req_err != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {28'h0, req_ack, req_err}, 32'h0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_ea = mon_e.is_err ? 2'b00 : (2'b01 << mon_e.id);
          mon_ee = mon_e.is_err ? (2'b01 << mon_e.id) : 2'b00;
          chk("ack_err_event", {11'h0, req_ack, req_err, grant_id, rega, value},
              {11'h0, mon_ea, mon_ee, mon_e.id[0], mon_e.rega, mon_e.value});
        end
      end
    end
  end

  // Send run-length monitor: recovery gap and timeout duration.
  bit gap_en = 1'b0;
  bit tmo_en = 1'b0;
  logic prev_send;
  int lo_run, hi_run;
  bit fell;
  initial begin
    prev_send = 1'b0; lo_run = 0; hi_run = 0; fell = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_send = 1'b0; lo_run = 0; hi_run = 0; fell = 1'b0;
      end else begin
        if (send && !prev_send) begin
          if (gap_en && fell) chk("gap_low_cycles", lo_run, GAP + 1);
          hi_run = 1;
        end else if (send) begin
          hi_run++;
        end else if (prev_send) begin
          if (tmo_en) chk("timeout_high_cycles", hi_run, TMO);
          fell = 1'b1;
          lo_run = 1;
        end else begin
          lo_run++;
        end
        prev_send = send;
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_cmd   = 32'h0;
    spur      = 1'b0;
    eng_en    = 1'b0;
    eng_delay = 1;
`ifdef SCCB_ARB_LOCK_EN
    req_lock  = 2'b00;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_events(input string nm, input int n, input int budget, output int cyc);
    int seen;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (req_ack != 2'b00 || req_err != 2'b00) seen++;
    end
    chk(nm, seen, n);
  endtask

  int cyc;

  initial begin
    // Test 1: single requester, reset state, latency, GAP length.
    do_reset();
    chk("reset_state", {19'h0, send, busy, grant_id, req_ack, req_err, rega, value}, 32'h0);
    eng_en = 1'b1; eng_delay = 5;
    exp_q.push_back('{1'b0, 4'd0, 8'h12, 8'h80});
    req_cmd[15:0] = 16'h1280;
    req_valid     = 2'b01;
    @(negedge clk);
    chk("t1_send_latency", {31'h0, send}, 32'h1);
    chk("t1_rega_value", {16'h0, rega, value}, 32'h1280);
    chk("t1_busy_grant", {30'h0, busy, grant_id}, 32'h2);
    run_events("t1_events", 1, 50, cyc);
    chk("t1_ack_cycle", cyc, 5);
    req_valid = 2'b00;
    chk("t1_busy_at_ack", {31'h0, busy}, 32'h1);
    repeat (15) @(negedge clk);
    chk("t1_busy_gap_end", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("t1_busy_idle", {31'h0, busy}, 32'h0);
    chk("t1_queue_drained", exp_q.size(), 0);

    // Test 2: both requesters continuously valid, grants alternate.
    do_reset();
    eng_en = 1'b1; eng_delay = 2; gap_en = 1'b1;
    exp_q.push_back('{1'b0, 4'd0, 8'hFF, 8'h01});
    exp_q.push_back('{1'b0, 4'd1, 8'h11, 8'h3F});
    exp_q.push_back('{1'b0, 4'd0, 8'hFF, 8'h01});
    exp_q.push_back('{1'b0, 4'd1, 8'h11, 8'h3F});
    req_cmd   = {16'h113F, 16'hFF01};
    req_valid = 2'b11;
    run_events("t2_events", 4, 400, cyc);
    req_valid = 2'b00; gap_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("t2_queue_drained", exp_q.size(), 0);
    chk("t2_idle", {31'h0, busy}, 32'h0);

    // Test 3: engine never answers, both time out in turn.
    do_reset();
    tmo_en = 1'b1;
    exp_q.push_back('{1'b1, 4'd0, 8'hAA, 8'h01});
    exp_q.push_back('{1'b1, 4'd1, 8'hBB, 8'h02});
    req_cmd   = {16'hBB02, 16'hAA01};
    req_valid = 2'b11;
    run_events("t3_events", 2, 400, cyc);
    req_valid = 2'b00; tmo_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_queue_drained", exp_q.size(), 0);

    // Test 4: async reset mid-ISSUE, then re-grant and single ack.
    do_reset();
    req_cmd[15:0] = 16'h3456;
    req_valid     = 2'b01;
    repeat (2) @(negedge clk);
    chk("t4_send_before_rst", {31'h0, send}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_clear", {29'h0, send, busy, grant_id}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    eng_en = 1'b1; eng_delay = 3;
    exp_q.push_back('{1'b0, 4'd0, 8'h34, 8'h56});
    run_events("t4_events", 1, 50, cyc);
    req_valid = 2'b00;
    repeat (30) @(negedge clk);
    chk("t4_queue_drained", exp_q.size(), 0);

    // Test 5: stray taken in IDLE and GAP; valid dropped mid-ISSUE.
    do_reset();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("t5_idle_spur", {31'h0, busy}, 32'h0);
    exp_q.push_back('{1'b0, 4'd0, 8'h5A, 8'h5A});
    req_cmd[15:0] = 16'h5A5A;
    req_valid     = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    req_cmd   = 32'h0;
    @(negedge clk);
    chk("t5_latched", {15'h0, send, rega, value}, {15'h0, 1'b1, 16'h5A5A});
    eng_en = 1'b1; eng_delay = 4;
    run_events("t5_events", 1, 50, cyc);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_gap_spur", {30'h0, busy, send}, 32'h2);
    repeat (20) @(negedge clk);
    chk("t5_idle_after", {31'h0, busy}, 32'h0);
    chk("t5_queue_drained", exp_q.size(), 0);

`ifdef SCCB_ARB_LOCK_EN
    // Test 6: lock keeps requester 0 for a burst of three, then requester 1.
    do_reset();
    eng_en = 1'b1; eng_delay = 2;
    req_lock = 2'b01;
    exp_q.push_back('{1'b0, 4'd0, 8'hC0, 8'h01});
    exp_q.push_back('{1'b0, 4'd0, 8'hC1, 8'h02});
    exp_q.push_back('{1'b0, 4'd0, 8'hC2, 8'h03});
    exp_q.push_back('{1'b0, 4'd1, 8'hD0, 8'h02});
    req_cmd   = {16'hD002, 16'hC001};
    req_valid = 2'b11;
    run_events("t6_ev1", 1, 100, cyc);
    req_cmd[15:0] = 16'hC102;
    run_events("t6_ev2", 1, 100, cyc);
    req_cmd[15:0] = 16'hC203;
    req_lock = 2'b00;
    run_events("t6_ev3", 1, 100, cyc);
    run_events("t6_ev4", 1, 100, cyc);
    req_valid = 2'b00;
    repeat (20) @(negedge clk);
    chk("t6_queue_drained", exp_q.size(), 0);

    // Test 7: timeout during lock releases it.
    do_reset();
    req_lock = 2'b01;
    exp_q.push_back('{1'b1, 4'd0, 8'hE0, 8'h01});
    exp_q.push_back('{1'b0, 4'd1, 8'hF0, 8'h02});
    req_cmd   = {16'hF002, 16'hE001};
    req_valid = 2'b11;
    run_events("t7_ev1", 1, 200, cyc);
    eng_en = 1'b1; eng_delay = 2;
    run_events("t7_ev2", 1, 100, cyc);
    req_valid = 2'b00; req_lock = 2'b00;
    repeat (20) @(negedge clk);
    chk("t7_queue_drained", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sccb_cmd_arbiter.md
Name: sccb_cmd_arbiter

Overview:
- Shares the single SCCB write engine (send/taken/rega/value handshake, SID fixed inside the engine) among NUM_REQ command sources.
- Typical sources: the boot-time register-LUT sequencer, a runtime exposure/gain tuner and a debug/UART register poker.
- Uses round-robin arbitration, one 16-bit command ({rega, value}) per grant.
- Sits between the requesters and the SCCB engine, inside the camera controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GAP_CYCLES, 16, idle cycles enforced after each accepted command before the next grant (bus recovery).
- TIMEOUT_CYCLES, 2_000_000, maximum cycles to wait for taken after send rises; 40 ms at 50 MHz.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  requester i has a command pending; held until req_ack[i]
- req_cmd  in  16*NUM_REQ  command of requester i at [16i+15:16i], {rega[15:8], value[7:0]}; stable while valid
- req_ack  out  NUM_REQ  one-cycle pulse: command i accepted by engine
- req_err  out  NUM_REQ  one-cycle pulse: command i aborted on timeout
- send  out  1  to engine: command present
- rega  out  8  to engine: register address
- value  out  8  to engine: register data
- taken  in  1  from engine: one-cycle pulse, command latched
- busy  out  1  state != IDLE
- grant_id  out  max(1,$clog2(NUM_REQ))  index of current or last winner

Behaviour:
- Reset (async, any state): state=IDLE; send=0, rega=0, value=0, req_ack=0, req_err=0, busy=0, grant_id=0; rr pointer=0; counters=0.
- Reset mid-transfer drops send immediately and the command is not acked. The requester must keep valid and is re-arbitrated after reset.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - If any req_valid: winner = first set bit scanning from rr pointer upward with wrap.
  - Register winner's cmd into rega/value and set grant_id; next cycle send=1, go ISSUE.
  - Grant latency: 1 cycle from valid to send.
- ISSUE:
  - send held 1; rega/value frozen; timeout counter increments.
  - taken=1: send=0, req_ack[grant]=1 for exactly one cycle, rr pointer = grant+1 (wrap at NUM_REQ), go GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without taken: send=0, req_err[grant]=1 for one cycle, rr pointer advances, go GAP.
  - Requester dropping req_valid during ISSUE is ignored; the command completes as latched.
  - taken in IDLE or GAP is ignored.
- GAP: count GAP_CYCLES cycles with send=0, then IDLE. Arbitration occurs only in IDLE.
- Simultaneous requests: exactly one grant per transaction. Starvation bound is NUM_REQ-1 transactions.
- busy=1 in ISSUE and GAP.
- Minimum period per command = 1 + engine accept latency + GAP_CYCLES + 1.
- req_ack and req_err are mutually exclusive and never both pulse for one grant.

Optional Feature:
- SCCB_ARB_LOCK_EN:
  - Adds input req_lock[NUM_REQ].
  - If req_lock[grant] is high when the command is acked, rr pointer is not advanced and that requester keeps priority for its next command. Multi-register bursts, e.g. a bank-select then writes, are not interleaved.
  - Lock ends at the first ack or err with req_lock low, or on timeout error regardless of lock.
- Without the macro: pure round-robin, no req_lock port.

Decomposition:
- Package sccb_pkg:
  - state enum (IDLE/ISSUE/GAP)
  - SCCB_CMD_W=16, REGA_MSB=15, VALUE_MSB=7
  - default GAP/TIMEOUT constants
  - command field extract helper
- One sub-module: rr_pick, a combinational round-robin priority picker taking (valid vector, pointer) and returning (found, index). Reused by other bus arbiters.

Test Plan:
- Single requester, NUM_REQ=2: req_valid=01, cmd=0x12_80; engine pulses taken 5 cycles after send -> send=1 one cycle after valid, rega=0x12, value=0x80, req_ack=01 one cycle, busy low after 16 GAP cycles.
- Both valid continuously, cmds 0xFF_01 / 0x11_3F -> grants alternate 0,1,0,1; each ack matches its cmd; send stays low ≥16 cycles between commands.
- TIMEOUT_CYCLES=100, taken never pulses -> send drops at cycle 100, req_err[grant]=1 one cycle, no ack, next requester granted after GAP.
- Async rst asserted mid-ISSUE -> send=0 within the same cycle with no clock; after release, still-valid requester is re-granted and acked once.
- Spurious taken in IDLE and GAP -> no ack, no state change; requester drops valid mid-ISSUE -> command still completes with its latched value.
- SCCB_ARB_LOCK_EN: req0 lock=1 for 3 commands while req1 valid -> grants 0,0,0 then 1; timeout during lock releases it.
